inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 pc  in  32  current fetch address from program counter; byte address, word = 16 bits.
REQ-004 pc_src  in  1  redirect: PC loads branch target at this edge; flush all in-flight fetch work.
REQ-005 fetch_stall  out  1  1 = PC holds its value this cycle; 0 = PC advances by 2.
REQ-006 mem_req  out  1  instruction-memory read request.
REQ-007 mem_addr  out  32  read address, stable while mem_req=1.
REQ-008 mem_ack  in  1  read complete; mem_rdata valid this cycle.
REQ-009 mem_rdata  in  16  returned instruction word.
REQ-010 if_valid  out  1  decode-stage output holds an instruction.
REQ-011 if_ready  in  1  decode stage accepts the instruction this cycle.
REQ-012 if_instr  out  32  {word0, word1}, or {word0, 16'h0} for short instructions.
REQ-013 if_pc  out  32  address of word0.
REQ-014 if_long  out  1  1 = two-word instruction.

Function
REQ-015 FSM states: IDLE, FETCH1, FETCH2, SKIP, DRAIN.
REQ-016 slot_free = !if_valid || if_ready.
REQ-017 IDLE, pc_src=0, slot_free=1: capture pc into pc_q; go to FETCH1; fetch_stall=0.
REQ-018 IDLE otherwise: fetch_stall=1; no capture.
REQ-019 FETCH1: mem_req=1, mem_addr=pc_q, fetch_stall=1; ack may arrive in the first FETCH1 cycle (minimum latency 1 cycle from capture).
REQ-020 FETCH1 ack, mem_rdata[15]=0: load output with if_instr={rdata,16'h0}, if_pc=pc_q, if_long=0, if_valid=1; go to IDLE.
REQ-021 FETCH1 ack, mem_rdata[15]=1: latch word0; go to FETCH2.
REQ-022 FETCH2: mem_req=1, mem_addr=pc_q+2 (32-bit wrap), fetch_stall=1.
REQ-023 FETCH2 ack: load output with {word0,rdata}, if_long=1, if_valid=1; go to SKIP.
REQ-024 SKIP: fetch_stall=0 for exactly one cycle so PC passes the immediate word; no capture; go to IDLE.
REQ-025 if_valid clears on if_valid&&if_ready unless reloaded the same edge; if_instr/if_pc/if_long stay stable while if_valid=1 and if_ready=0.
REQ-026 pc_src=1 in any state: if_valid cleared at this edge; no pc capture this cycle.
REQ-027 pc_src=1 in FETCH1/FETCH2 without ack: go to DRAIN; with ack the same cycle: discard data, go to IDLE.
REQ-028 pc_src=1 in IDLE/SKIP/DRAIN: go to IDLE, or stay in DRAIN if no ack.
REQ-029 DRAIN: mem_req=1 with the original address, fetch_stall=1; on ack discard data, go to IDLE.
REQ-030 pc_src takes priority over capture, ack loading and if_ready.
REQ-031 No new request while a memory request is outstanding; at most one outstanding read.

Reset
REQ-032 reset=0: state=IDLE, if_valid=0, mem_req=0, if_instr=0, if_pc=0, if_long=0, pc_q=0; fetch_stall=1 during reset.
REQ-033 Reset overrides pc_src and mem_ack; an outstanding memory read is abandoned, and the memory side is reset together with this block.

Structure
REQ-034 Shared package holds the state enum, LONG_BIT=15, WORD_BYTES=2 and the 32-bit address width constant.
REQ-035 One sub-module, fetch_out_reg: the decode-side valid/ready holding register (load, clear, hold).

Verification
REQ-036 Release reset with PC at 32'd30, ack 1 cycle, word 16'h1234, if_ready=1 -> mem_addr=30, if_instr=32'h12340000, if_pc=30, if_long=0; next capture pc=32.
REQ-037 Word0 16'h8001 at 40, word1 16'hBEEF at 42 -> mem_addr 40 then 42, if_instr=32'h8001BEEF, if_long=1; one SKIP cycle with fetch_stall=0; next capture pc=44.
REQ-038 if_ready=0 for 5 cycles after if_valid -> outputs stable, fetch_stall=1, mem_req=0 throughout; capture occurs in the cycle if_ready rises.
REQ-039 pc_src=1 during FETCH1 with ack delayed 3 cycles -> DRAIN with mem_addr held, data discarded, if_valid never set; branch target captured on the cycle after ack.
REQ-040 pc_src=1 in the same cycle as if_valid&&if_ready=0 and a FETCH2 ack -> if_valid=0 next cycle, state IDLE, no SKIP cycle.
REQ-041 reset=0 asserted mid-FETCH2 -> next cycle mem_req=0, if_valid=0, state IDLE.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int LONG_BIT = 15;
  localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    SKIP,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_out_reg.sv
// rtl/inst_fetch_out_reg.sv - decode-side valid/ready holding register
module fetch_out_reg
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              ready,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              load_long,
  output logic              valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              is_long
);

  // Flush beats load beats consume; payload is only written on load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid   <= 1'b0;
      instr   <= '0;
      pc      <= '0;
      is_long <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= load_instr;
      pc      <= load_pc;
      is_long <= load_long;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - variable-length (16/32-bit) instruction fetch FSM
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_src,
  output logic              fetch_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_long
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [15:0]       word0_q;
  logic              slot_free;
  logic              capture;
  logic              latch_word0;
  logic              load;
  logic [31:0]       load_instr;
  logic              load_long;

  assign slot_free = !if_valid || if_ready;

  always_comb begin
    state_d     = state_q;
    fetch_stall = 1'b1;
    mem_req     = 1'b0;
    mem_addr    = pc_q;
    capture     = 1'b0;
    latch_word0 = 1'b0;
    load        = 1'b0;
    load_instr  = {mem_rdata, 16'h0};
    load_long   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!pc_src && slot_free) begin
          capture     = 1'b1;
          fetch_stall = 1'b0;
          state_d     = FETCH1;
        end
      end
      FETCH1: begin
        mem_req = 1'b1;
        if (pc_src) begin
          state_d = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          if (mem_rdata[LONG_BIT]) begin
            latch_word0 = 1'b1;
            state_d     = FETCH2;
          end else begin
            load    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FETCH2: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + WORD_BYTES;
        if (pc_src) begin
          state_d = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          load       = 1'b1;
          load_instr = {word0_q, mem_rdata};
          load_long  = 1'b1;
          state_d    = SKIP;
        end
      end
      SKIP: begin
        // Lets the PC step over the immediate word of a long instruction.
        fetch_stall = 1'b0;
        state_d     = IDLE;
      end
      DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = req_addr_q;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      fetch_stall = 1'b1;
      mem_req     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      word0_q    <= '0;
      req_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) pc_q <= pc;
      if (latch_word0) word0_q <= mem_rdata;
      // Remember the live request address so a drain keeps presenting it.
      if (state_q == FETCH1 || state_q == FETCH2) req_addr_q <= mem_addr;
    end
  end

  fetch_out_reg u_out (
    .clk        (clk),
    .reset      (reset),
    .flush      (pc_src),
    .load       (load),
    .ready      (if_ready),
    .load_instr (load_instr),
    .load_pc    (pc_q),
    .load_long  (load_long),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .is_long    (if_long)
  );

endmodule
